lfsr_snapshot_decoder: RTL and testbench

Downstream consumer of the 64-bit hybrid LFSR/binary counter value, formatted as {58-bit binary high field, 6-bit Galois LFSR low field}.
- On a capture handshake it freezes one sample of that value.
- It converts the LFSR low field to its binary sequence index by stepping a local LFSR copy from the seed until it matches.
- It returns the decoded result over a valid/ready handshake to the readout or register interface.
- Fully synchronous to the counter clock.

---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/lfsr_index_search.sv | 52 +++++
 rtl/lfsr_snapshot_decoder.sv | 111 +++++++++++
 tb/tb_lfsr_snapshot_decoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR snapshot decoder.
// Holds the field widths, the LFSR seed and period, the FSM state enum and the
// one-step Galois LFSR update used both by the decoder and any model of it.
package lfsr_pkg;
  localparam int HI_W   = 58;
  localparam int LFSR_W = 6;
  localparam int CNT_W  = HI_W + LFSR_W;
  localparam int PERIOD = (1 << LFSR_W) - 1;

  // Seed is the sequence origin: the LFSR state that decodes to index 0.
  localparam logic [LFSR_W-1:0] SEED = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Shift up by one, wrap the MSB into bit 0, and fold the MSB into the top
  // tap. 3F -> 1F -> 3E -> ...
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2] ^ s[LFSR_W-1], s[LFSR_W-3:0], s[LFSR_W-1]};
  endfunction
endpackage

// File: rtl/lfsr_index_search.sv
// Sequential LFSR-state-to-index search.
// start_i  : (re)load the search register with SEED and clear the step count
// active_i : a search is in progress; compare/step this cycle
// target_i : frozen LFSR state being decoded
// done_o   : search resolves at the coming edge (hit or sequence exhausted)
// idx_o    : step count of the hit, 0 when not found
// err_o    : target never appeared in the sequence (only meaningful with done_o)
module lfsr_index_search
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_i,
  input  logic              active_i,
  input  logic [LFSR_W-1:0] target_i,
  output logic              done_o,
  output logic [LFSR_W-1:0] idx_o,
  output logic              err_o
);
  logic [LFSR_W-1:0] srch_q, srch_d;
  logic [LFSR_W-1:0] k_q, k_d;
  logic              hit, last;

  always_comb begin
    hit    = (srch_q == target_i);
    // The compare has priority over exhaustion, so the final state of the
    // sequence (k = PERIOD-1) still decodes as a hit.
    last   = (k_q == LFSR_W'(PERIOD - 1));
    done_o = active_i & (hit | last);
    err_o  = ~hit;
    idx_o  = hit ? k_q : '0;
    srch_d = srch_q;
    k_d    = k_q;
    if (start_i) begin
      srch_d = SEED;
      k_d    = '0;
    end else if (active_i && !hit && !last) begin
      srch_d = lfsr_step(srch_q);
      k_d    = k_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      srch_q <= '0;
      k_q    <= '0;
    end else begin
      srch_q <= srch_d;
      k_q    <= k_d;
    end
  end
endmodule

// File: rtl/lfsr_snapshot_decoder.sv
// Captures one sample of the {binary hi, Galois LFSR lo} counter and decodes
// the LFSR field to its sequence index, returning the result over valid/ready.
// Optional build macro LINEAR_COUNT_EN adds out_lin = hi*PERIOD + idx.
// clk, nrst          : clock, async active-low reset
// cap_valid/cap_ready: capture handshake (ready only while idle)
// cnt_in             : live counter value {hi, lfsr}
// out_valid/out_ready: result handshake; outputs hold while stalled
// out_hi/out_idx/out_err : captured hi field, decoded index, not-in-sequence flag
// out_lin            : linear count (LINEAR_COUNT_EN only)
module lfsr_snapshot_decoder
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              cap_valid,
  output logic              cap_ready,
  input  logic [CNT_W-1:0]  cnt_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HI_W-1:0]   out_hi,
  output logic [LFSR_W-1:0] out_idx,
  output logic              out_err
`ifdef LINEAR_COUNT_EN
  ,
  output logic [63:0]       out_lin
`endif
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  snap_q;
  logic [HI_W-1:0]   out_hi_q;
  logic [LFSR_W-1:0] out_idx_q;
  logic              out_err_q;
  logic              start;
  logic              srch_done, srch_err;
  logic [LFSR_W-1:0] srch_idx;

  lfsr_index_search u_search (
    .clk      (clk),
    .nrst     (nrst),
    .start_i  (start),
    .active_i (state_q == SEARCH),
    .target_i (snap_q[LFSR_W-1:0]),
    .done_o   (srch_done),
    .idx_o    (srch_idx),
    .err_o    (srch_err)
  );

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    cap_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        cap_ready = 1'b1;
        if (cap_valid) begin
          start   = 1'b1;
          state_d = SEARCH;
        end
      end
      SEARCH: if (srch_done) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      out_hi_q  <= '0;
      out_idx_q <= '0;
      out_err_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) snap_q <= cnt_in;
      // Result registers load only on entry to DONE, so they stay frozen for
      // as long as the consumer stalls.
      if (srch_done) begin
        out_hi_q  <= snap_q[CNT_W-1:LFSR_W];
        out_idx_q <= srch_idx;
        out_err_q <= srch_err;
      end
    end
  end

  assign out_hi  = out_hi_q;
  assign out_idx = out_idx_q;
  assign out_err = out_err_q;

`ifdef LINEAR_COUNT_EN
  logic [63:0] lin_q, lin_d, hi_ext;

  // hi*PERIOD + idx as (hi<<W) - hi + idx, modulo 2^64.
  always_comb begin
    hi_ext = {{(64-HI_W){1'b0}}, snap_q[CNT_W-1:LFSR_W]};
    lin_d  = srch_err ? 64'd0
                      : (hi_ext << LFSR_W) - hi_ext + {{(64-LFSR_W){1'b0}}, srch_idx};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)          lin_q <= '0;
    else if (srch_done) lin_q <= lin_d;
  end

  assign out_lin = lin_q;
`endif
endmodule

// File: tb/tb_lfsr_snapshot_decoder.sv
module tb_lfsr_snapshot_decoder;
  logic        clk = 1'b0;
  logic        nrst;
  logic        cap_valid;
  logic        cap_ready;
  logic [63:0] cnt_in;
  logic        out_valid;
  logic        out_ready;
  logic [57:0] out_hi;
  logic [5:0]  out_idx;
  logic        out_err;
`ifdef LINEAR_COUNT_EN
  logic [63:0] out_lin;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference: index of each 6-bit LFSR state, -1 for states off the sequence.
  int seq_idx [64];

  lfsr_snapshot_decoder dut (
    .clk       (clk),
    .nrst      (nrst),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .cnt_in    (cnt_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hi    (out_hi),
    .out_idx   (out_idx),
    .out_err   (out_err)
`ifdef LINEAR_COUNT_EN
    ,
    .out_lin   (out_lin)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ref_step(input logic [5:0] s);
    logic [5:0] n;
    n[0] = s[5];
    for (int i = 1; i < 5; i++) n[i] = s[i-1];
    n[5] = s[4] ^ s[5];
    return n;
  endfunction

  task automatic build_model();
    logic [5:0] s;
    for (int i = 0; i < 64; i++) seq_idx[i] = -1;
    s = 6'h3F;
    for (int k = 0; k < 63; k++) begin
      seq_idx[s] = k;
      s = ref_step(s);
    end
  endtask

  // Expected result for a captured value, straight from the decoding rules.
  task automatic model(input logic [63:0] v, output logic [5:0] ei, output logic ee,
                       output int el, output logic [63:0] elin);
    int k;
    k = seq_idx[v[5:0]];
    ee   = (k < 0);
    ei   = ee ? 6'd0 : 6'(k);
    el   = ee ? 63 : k + 1;
    elin = ee ? 64'd0 : {6'd0, v[63:6]} * 64'd63 + 64'(ei);
  endtask

  // Present one capture and count edges until out_valid (bounded).
  task automatic capture(input logic [63:0] v, output int lat);
    @(negedge clk);
    cap_valid = 1'b1;
    cnt_in    = v;
    @(posedge clk);
    #1;
    cap_valid = 1'b0;
    cnt_in    = {$urandom(), $urandom()};  // snapshot must not track cnt_in
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; cap_valid = 1'b0; out_ready = 1'b0; cnt_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (cap_ready !== 1'b1) begin n_err++; $display("FAIL reset_cap_ready got %b want 1", cap_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_hi !== 58'd0) begin n_err++; $display("FAIL reset_out_hi got %h want 0", out_hi); end
    n_cmp++; if (out_idx !== 6'd0) begin n_err++; $display("FAIL reset_out_idx got %h want 0", out_idx); end
    n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err got %b want 0", out_err); end
`ifdef LINEAR_COUNT_EN
    n_cmp++; if (out_lin !== 64'd0) begin n_err++; $display("FAIL reset_out_lin got %h want 0", out_lin); end
`endif
  endtask

  task automatic test_directed();
    logic [63:0] vals [6];
    logic [5:0]  ei;
    logic        ee;
    int          el, lat;
    logic [63:0] elin;
    vals[0] = {58'd5, 6'h3F};
    vals[1] = {58'd5, 6'h1F};
    vals[2] = {58'd0, 6'h3E};
    vals[3] = {58'd7, 6'h00};
    vals[4] = {58'h3FF_FFFF_FFFF_FFFF, 6'h1F};
    vals[5] = {58'd1, 6'h00};
    for (int t = 0; t < 6; t++) begin
      model(vals[t], ei, ee, el, elin);
      capture(vals[t], lat);
      n_cmp++; if (lat != el) begin n_err++; $display("FAIL dir_latency v=%h got %0d want %0d", vals[t], lat, el); end
      n_cmp++; if (out_hi !== vals[t][63:6]) begin n_err++; $display("FAIL dir_hi v=%h got %h want %h", vals[t], out_hi, vals[t][63:6]); end
      n_cmp++; if (out_idx !== ei) begin n_err++; $display("FAIL dir_idx v=%h got %0d want %0d", vals[t], out_idx, ei); end
      n_cmp++; if (out_err !== ee) begin n_err++; $display("FAIL dir_err v=%h got %b want %b", vals[t], out_err, ee); end
`ifdef LINEAR_COUNT_EN
      n_cmp++; if (out_lin !== elin) begin n_err++; $display("FAIL dir_lin v=%h got %0d want %0d", vals[t], out_lin, elin); end
`endif
      release_out();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir_valid_drop got %b want 0", out_valid); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    capture({58'd9, 6'h3E}, lat);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL bp_latency got %0d want 3", lat); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cap_valid = c[0];
      cnt_in    = {58'd77, 6'h3F};
      @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid c=%0d got %b want 1", c, out_valid); end
      n_cmp++; if (cap_ready !== 1'b0) begin n_err++; $display("FAIL bp_cap_ready c=%0d got %b want 0", c, cap_ready); end
      n_cmp++; if (out_hi !== 58'd9 || out_idx !== 6'd2 || out_err !== 1'b0) begin
        n_err++; $display("FAIL bp_hold c=%0d got hi=%0d idx=%0d err=%b want 9/2/0", c, out_hi, out_idx, out_err);
      end
    end
    cap_valid = 1'b0;
    release_out();
    // No queued capture may surface after the handshake.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_queue c=%0d got %b want 0", c, out_valid); end
    end
    capture({58'd77, 6'h3F}, lat);
    n_cmp++; if (lat != 1 || out_hi !== 58'd77 || out_idx !== 6'd0) begin
      n_err++; $display("FAIL bp_next_capture got lat=%0d hi=%0d idx=%0d want 1/77/0", lat, out_hi, out_idx);
    end
    release_out();
  endtask

  task automatic test_reset_mid_search();
    int seen;
    @(negedge clk);
    cap_valid = 1'b1;
    cnt_in    = {58'd3, 6'h00};
    @(posedge clk);
    #1;
    cap_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    n_cmp++; if (cap_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_state got cap_ready=%b out_valid=%b want 1/0", cap_ready, out_valid);
    end
    @(negedge clk);
    nrst = 1'b1;
    seen = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midreset_lost got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_sweep();
    logic [5:0]  s;
    logic [63:0] v;
    int          lat;
    s = 6'h3F;
    for (int k = 0; k < 63; k++) begin
      v = {$urandom(), $urandom()};
      v[5:0] = s;
      capture(v, lat);
      n_cmp++; if (lat != k + 1) begin n_err++; $display("FAIL sweep_latency k=%0d got %0d want %0d", k, lat, k + 1); end
      n_cmp++; if (out_idx !== 6'(k) || out_err !== 1'b0) begin
        n_err++; $display("FAIL sweep_idx k=%0d got idx=%0d err=%b want %0d/0", k, out_idx, out_err, k);
      end
      release_out();
      s = ref_step(s);
    end
  endtask

  task automatic test_random();
    logic [63:0] v, elin;
    logic [5:0]  ei;
    logic        ee;
    int          el, lat;
    for (int t = 0; t < 20; t++) begin
      v = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) v[5:0] = 6'h00;
      model(v, ei, ee, el, elin);
      capture(v, lat);
      n_cmp++; if (lat != el) begin n_err++; $display("FAIL rnd_latency v=%h got %0d want %0d", v, lat, el); end
      n_cmp++; if (out_hi !== v[63:6] || out_idx !== ei || out_err !== ee) begin
        n_err++; $display("FAIL rnd_result v=%h got hi=%h idx=%0d err=%b want %h/%0d/%b", v, out_hi, out_idx, out_err, v[63:6], ei, ee);
      end
`ifdef LINEAR_COUNT_EN
      n_cmp++; if (out_lin !== elin) begin n_err++; $display("FAIL rnd_lin v=%h got %0d want %0d", v, out_lin, elin); end
`endif
      // Random stall before accepting the result.
      repeat ($urandom_range(0, 3)) @(posedge clk);
      release_out();
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_search();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
